// File: rtl/eda_region_ctrl.sv
// Traversal controller for regional-maximum detection: raster-scans seed pixels and
// flood-fills each equal-valued 8-connected region through an internal address stack.
module eda_region_ctrl #(
  parameter int M           = 3,
  parameter int N           = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  win_req,
  output logic [ADDR_WIDTH-1:0] win_addr,
  input  logic                  win_ack,
  input  logic                  center_iterated,
  output logic                  new_pixel,
  input  logic                  compare_out,
  input  logic [7:0]            push_positions,
  output logic                  iter_set,
  output logic [ADDR_WIDTH-1:0] iter_addr,
  output logic                  region_done,
  output logic                  region_is_max,
  output logic [ADDR_WIDTH:0]   region_size,
  output logic                  overflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(M * N - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW      = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   SIZE_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [SPW-1:0]        SP_ONE   = SPW'(1);
  localparam logic [SPW-1:0]        FULL     = SPW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SEED_REQ, POP, FETCH, PUSH, REG_END, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] seed_addr, cur_addr;
  logic [SPW-1:0]        sp, sp_after;
  logic [7:0]            mask, mask_nx;
  logic                  is_max;
  logic [ADDR_WIDTH:0]   size;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  logic                  clear_run, seed_next, seed_take, pop_en, fetch_take;
  logic                  push_req, push_en;
  logic [ADDR_WIDTH-1:0] push_addr, neigh_addr;
  logic [2:0]            k;

  assign busy = (state != IDLE);

  // Lowest pending neighbour and its address; window offsets skip the centre slot.
  always_comb begin
    k = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) k = 3'(i);
    end
    mask_nx    = mask & (mask - 8'd1);
    neigh_addr = cur_addr;
    case (k)
      3'd0: neigh_addr = cur_addr - ROW - ONE;
      3'd1: neigh_addr = cur_addr - ROW;
      3'd2: neigh_addr = cur_addr - ROW + ONE;
      3'd3: neigh_addr = cur_addr - ONE;
      3'd4: neigh_addr = cur_addr + ONE;
      3'd5: neigh_addr = cur_addr + ROW - ONE;
      3'd6: neigh_addr = cur_addr + ROW;
      3'd7: neigh_addr = cur_addr + ROW + ONE;
    endcase
  end

  assign push_en  = push_req && (sp < FULL);
  assign sp_after = sp + SPW'(push_en);

  // NOTE: every signal written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    win_req       = 1'b0;
    win_addr      = '0;
    new_pixel     = 1'b0;
    iter_set      = 1'b0;
    iter_addr     = '0;
    region_done   = 1'b0;
    region_is_max = 1'b0;
    region_size   = '0;
    done          = 1'b0;
    clear_run     = 1'b0;
    seed_next     = 1'b0;
    seed_take     = 1'b0;
    pop_en        = 1'b0;
    fetch_take    = 1'b0;
    push_req      = 1'b0;
    push_addr     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_run = 1'b1;
          state_nx  = SEED_REQ;
        end
      end
      SEED_REQ: begin
        win_req  = 1'b1;
        win_addr = seed_addr;
        if (win_ack) begin
          if (center_iterated) begin
            seed_next = 1'b1;
          end else begin
            iter_set  = 1'b1;
            iter_addr = seed_addr;
            push_req  = 1'b1;
            push_addr = seed_addr;
            seed_take = 1'b1;
            state_nx  = POP;
          end
        end
      end
      POP: begin
        pop_en   = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        win_req  = 1'b1;
        win_addr = cur_addr;
        if (win_ack) begin
          new_pixel  = 1'b1;
          fetch_take = 1'b1;
          state_nx   = PUSH;
        end
      end
      PUSH: begin
        if (mask != 8'd0) begin
          iter_set  = 1'b1;
          iter_addr = neigh_addr;
          push_req  = 1'b1;
          push_addr = neigh_addr;
        end
        if (mask_nx == 8'd0) state_nx = (sp_after != '0) ? POP : REG_END;
      end
      REG_END: begin
        region_done   = 1'b1;
        region_is_max = is_max;
        region_size   = size;
        seed_next     = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (seed_next) state_nx = (seed_addr == LAST) ? DONE : SEED_REQ;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_addr <= '0;
      cur_addr  <= '0;
      sp        <= '0;
      mask      <= '0;
      is_max    <= 1'b0;
      size      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (clear_run) begin
        seed_addr <= '0;
        overflow  <= 1'b0;
      end
      if (seed_next && (seed_addr != LAST)) seed_addr <= seed_addr + ONE;

      if (clear_run)   sp <= '0;
      else if (pop_en) sp <= sp - SP_ONE;
      else             sp <= sp_after;

      if (pop_en) cur_addr <= stack[IW'(sp - SP_ONE)];

      if (seed_take) begin
        is_max <= 1'b1;
        size   <= '0;
      end else if (fetch_take) begin
        is_max <= is_max & compare_out;
        size   <= size + SIZE_ONE;
      end

      if (fetch_take)          mask <= push_positions;
      else if (state == PUSH)  mask <= mask_nx;

      if (push_req && !push_en) overflow <= 1'b1;
    end
  end

  // NOTE: the stack array is not reset; sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stack[IW'(sp)] <= push_addr;
  end

endmodule

// File: tb/tb_eda_region_ctrl.sv
// Scoreboard bench for eda_region_ctrl: a 4x4 instance (deep stack) and a 3x3 instance
// (two-entry stack), each served by a behavioural window/compare model.
module tb_eda_region_ctrl;

  localparam int AW = 5;

  typedef struct {
    int size;
    bit is_max;
  } region_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start           [2];
  logic          busy            [2];
  logic          done            [2];
  logic          win_req         [2];
  logic [AW-1:0] win_addr        [2];
  logic          win_ack         [2];
  logic          center_iterated [2];
  logic          new_pixel       [2];
  logic          compare_out     [2];
  logic [7:0]    push_positions  [2];
  logic          iter_set        [2];
  logic [AW-1:0] iter_addr       [2];
  logic          region_done     [2];
  logic          region_is_max   [2];
  logic [AW:0]   region_size     [2];
  logic          overflow        [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    eda_region_ctrl #(
      .M(g == 0 ? 4 : 3), .N(g == 0 ? 4 : 3), .ADDR_WIDTH(AW), .STACK_DEPTH(g == 0 ? 64 : 2)
    ) dut (
      .clk(clk), .reset_n(reset_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .win_req(win_req[g]), .win_addr(win_addr[g]), .win_ack(win_ack[g]),
      .center_iterated(center_iterated[g]), .new_pixel(new_pixel[g]),
      .compare_out(compare_out[g]), .push_positions(push_positions[g]),
      .iter_set(iter_set[g]), .iter_addr(iter_addr[g]), .region_done(region_done[g]),
      .region_is_max(region_is_max[g]), .region_size(region_size[g]), .overflow(overflow[g])
    );
  end

  int            rows [2] = '{4, 3};
  int            cols [2] = '{4, 3};
  int            img      [2][32];
  bit            iterated [2][32];
  bit            delay_mode;
  bit            waiting   [2];
  int            wait_left [2];
  logic [AW-1:0] held_addr [2];
  int            iter_cnt  [2];
  int            pix_cnt   [2];
  int            done_cnt  [2];
  region_t       exp_q [$];
  int            vectors = 0;
  int            errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return 32'({busy[d], done[d], win_req[d], win_addr[d], new_pixel[d], iter_set[d],
                iter_addr[d], region_done[d], region_is_max[d], region_size[d], overflow[d]});
  endfunction

  // Compare model: centre is a candidate maximum unless a neighbour is larger;
  // equal-valued, not-yet-iterated in-image neighbours are flagged for pushing.
  function automatic logic [8:0] respond(input int d, input int a);
    int       dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int       dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int       r, c, n;
    logic     cmp = 1'b1;
    logic [7:0] m = 8'd0;
    for (int k = 0; k < 8; k++) begin
      r = a / cols[d] + dr[k];
      c = a % cols[d] + dc[k];
      if (r >= 0 && r < rows[d] && c >= 0 && c < cols[d]) begin
        n = r * cols[d] + c;
        if (img[d][n] > img[d][a]) cmp = 1'b0;
        if (img[d][n] == img[d][a] && !iterated[d][n]) m[k] = 1'b1;
      end
    end
    return {cmp, m};
  endfunction

  // Window responder: acks after 0 (or 0-3 random) cycles and holds the request address.
  initial begin
    logic [8:0] rsp;
    for (int d = 0; d < 2; d++) begin
      win_ack[d] = 1'b0; center_iterated[d] = 1'b0;
      compare_out[d] = 1'b0; push_positions[d] = 8'd0; waiting[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        win_ack[d] = 1'b0;
        if (win_req[d] && reset_n) begin
          if (!waiting[d]) begin
            waiting[d]   = 1'b1;
            wait_left[d] = delay_mode ? int'($urandom_range(3, 0)) : 0;
            held_addr[d] = win_addr[d];
          end else begin
            check("win_addr_stable", 32'(win_addr[d]), 32'(held_addr[d]));
          end
          if (wait_left[d] == 0) begin
            rsp                = respond(d, int'(win_addr[d]));
            win_ack[d]         = 1'b1;
            center_iterated[d] = iterated[d][win_addr[d]];
            compare_out[d]     = rsp[8];
            push_positions[d]  = rsp[7:0];
            waiting[d]         = 1'b0;
          end else begin
            wait_left[d]--;
          end
        end else begin
          waiting[d] = 1'b0;
        end
      end
    end
  end

  // Monitor: mid-cycle sampling of strobes, scoreboard pop on region_done.
  initial begin
    region_t e;
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 2; d++) begin
        if (iter_set[d]) begin
          check("iter_set_unmarked_target", 32'(iterated[d][iter_addr[d]]), 0);
          iterated[d][iter_addr[d]] = 1'b1;
          iter_cnt[d]++;
        end
        if (new_pixel[d]) begin
          check("new_pixel_with_ack", 32'(win_ack[d]), 1);
          pix_cnt[d]++;
        end
        if (region_done[d]) begin
          check("region_expected", 32'(exp_q.size() != 0), 1);
          check("region_done_vs_done", 32'(done[d]), 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("region_size", 32'(region_size[d]), 32'(e.size));
            check("region_is_max", 32'(region_is_max[d]), 32'(e.is_max));
          end
        end
        if (done[d]) begin
          done_cnt[d]++;
          check("regions_pending_at_done", 32'(exp_q.size()), 0);
        end
      end
    end
  end

  task automatic expect_region(input int s, input bit m);
    region_t r;
    r.size = s;
    r.is_max = m;
    exp_q.push_back(r);
  endtask

  task automatic fill(input int d, input int v);
    for (int i = 0; i < 32; i++) img[d][i] = v;
  endtask

  task automatic start_run(input int d);
    for (int i = 0; i < 32; i++) iterated[d][i] = 1'b0;
    iter_cnt[d] = 0; pix_cnt[d] = 0; done_cnt[d] = 0;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    #1;
    check("busy_after_start", 32'(busy[d]), 1);
  endtask

  task automatic wait_done(input int d, input int exp_iter, input int exp_pix);
    int n = 0;
    while (done_cnt[d] == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 32'(done_cnt[d] != 0), 1);
    repeat (4) @(negedge clk);
    #4;
    check("done_count", 32'(done_cnt[d]), 1);
    check("iter_set_count", 32'(iter_cnt[d]), 32'(exp_iter));
    check("new_pixel_count", 32'(pix_cnt[d]), 32'(exp_pix));
    check("busy_after_done", 32'(busy[d]), 0);
  endtask

  initial begin
    int  n;
    bit  found;
    reset_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    delay_mode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fill(d, 0);
      for (int i = 0; i < 32; i++) iterated[d][i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_dut0", outs(0), 0);
    check("reset_outputs_dut1", outs(1), 0);
    reset_n = 1'b1;

    // Uniform 4x4: one region covering the whole image.
    fill(0, 5);
    expect_region(16, 1'b1);
    start_run(0);
    wait_done(0, 16, 16);
    check("overflow_uniform", 32'(overflow[0]), 0);

    // Single peak at pixel 5 on a flat background.
    fill(0, 1); img[0][5] = 9;
    expect_region(15, 1'b0); expect_region(1, 1'b1);
    start_run(0);
    wait_done(0, 16, 16);

    // Same image with random ack latency.
    delay_mode = 1'b1;
    expect_region(15, 1'b0); expect_region(1, 1'b1);
    start_run(0);
    wait_done(0, 16, 16);
    delay_mode = 1'b0;

    // Two 7-plateaus on a 2 background; extra start pulse while busy is ignored.
    fill(0, 2);
    img[0][0] = 7; img[0][1] = 7; img[0][4] = 7;
    img[0][11] = 7; img[0][14] = 7; img[0][15] = 7;
    expect_region(3, 1'b1); expect_region(10, 1'b0); expect_region(3, 1'b1);
    start_run(0);
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 16, 16);

    // 3x3 uniform with a two-entry stack: pixels 4 and 7 are dropped.
    fill(1, 5);
    expect_region(7, 1'b1);
    start_run(1);
    wait_done(1, 9, 7);
    check("overflow_set", 32'(overflow[1]), 1);
    expect_region(7, 1'b1);
    start_run(1);
    check("overflow_cleared_by_start", 32'(overflow[1]), 0);
    wait_done(1, 9, 7);
    check("overflow_set_again", 32'(overflow[1]), 1);

    // Reset asserted while the controller is pushing neighbours.
    fill(0, 5);
    start_run(0);
    n = 0; found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      #3;
      found = iter_set[0] && !win_req[0];
      n++;
    end
    check("push_state_reached", 32'(found), 1);
    reset_n = 1'b0;
    #1;
    check("outputs_zero_in_reset", outs(0), 0);
    @(negedge clk);
    check("outputs_zero_next_cycle", outs(0), 0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt[0]), 0);
    check("idle_after_abort", 32'(busy[0]), 0);
    check("no_region_pending", 32'(exp_q.size()), 0);

    // Recovery run after the abort.
    expect_region(16, 1'b1);
    start_run(0);
    wait_done(0, 16, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
